acc_seq_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit invert/add/accumulate datapath (`modelo`). It accepts one command at a time over a valid/ready handshake and drives `A`, `sel0` and `sel1` cycle by cycle to execute LOAD, ADD, SUB or MUL. MUL is built from one clear step followed by repeated adds. Each result and a status flag are returned over a valid/ready response handshake.

---
 rtl/acc_seq_pkg.sv | 31 +++
 rtl/acc_seq_ctrl_modelo.sv | 35 +++
 rtl/acc_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Shared types and datapath drive encodings for the accumulator sequencer.
package acc_seq_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10,
    OpMul  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMclr,
    StMadd,
    StResp
  } state_t;

  // sel0 picks ~A with carry-in 1; sel1 bypasses the adder so S = A.
  localparam logic Sel0Load = 1'b0;
  localparam logic Sel1Load = 1'b1;
  localparam logic Sel0Add  = 1'b0;
  localparam logic Sel1Add  = 1'b0;
  localparam logic Sel0Sub  = 1'b1;
  localparam logic Sel1Sub  = 1'b0;
  localparam logic Sel0Hold = 1'b0;
  localparam logic Sel1Hold = 1'b0;

endpackage

// File: rtl/acc_seq_ctrl_modelo.sv
// Invert/add/accumulate datapath: S is the combinational next value, acc captures S every edge.
module modelo #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic             sel0,
  input  logic             sel1,
  output logic [WIDTH-1:0] S,
  output logic             somador_cout
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  // Operand inversion, adder with sel0 as carry-in, and load bypass.
  always_comb begin
    b            = sel0 ? ~A : A;
    sum          = {1'b0, acc_q} + {1'b0, b} + {{WIDTH{1'b0}}, sel0};
    S            = sel1 ? b : sum[WIDTH-1:0];
    somador_cout = sum[WIDTH];
  end

  // Accumulator register, active-high asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= S;
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Command sequencer driving the modelo datapath for LOAD/ADD/SUB/MUL with valid/ready handshakes.
module acc_seq_ctrl #(
  parameter int unsigned WIDTH = acc_seq_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag
);

  import acc_seq_pkg::*;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_flag_q, rsp_flag_d;

  logic [WIDTH-1:0] dp_a;
  logic             dp_sel0;
  logic             dp_sel1;
  logic [WIDTH-1:0] dp_s;
  logic             dp_cout;

  modelo #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset       (~reset),
    .A           (dp_a),
    .sel0        (dp_sel0),
    .sel1        (dp_sel1),
    .S           (dp_s),
    .somador_cout(dp_cout)
  );

  // Next-state, datapath drive and response capture; HOLD unless an op step is active.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    dp_a       = '0;
    dp_sel0    = Sel0Hold;
    dp_sel1    = Sel1Hold;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          a_d     = cmd_a;
          n_d     = cmd_n;
          state_d = (op_t'(cmd_op) == OpMul) ? StMclr : StExec;
        end
      end
      StExec: begin
        dp_a = a_q;
        if (op_q == OpLoad) begin
          dp_sel0 = Sel0Load;
          dp_sel1 = Sel1Load;
        end else if (op_q == OpSub) begin
          dp_sel0 = Sel0Sub;
          dp_sel1 = Sel1Sub;
        end else begin
          dp_sel0 = Sel0Add;
          dp_sel1 = Sel1Add;
        end
        rsp_data_d = dp_s;
        rsp_flag_d = (op_q == OpLoad) ? 1'b0 : dp_cout;
        state_d    = StResp;
      end
      StMclr: begin
        // Clear step: MUL starts from zero regardless of the prior accumulator.
        dp_a     = '0;
        dp_sel0  = Sel0Load;
        dp_sel1  = Sel1Load;
        sticky_d = 1'b0;
        cnt_d    = n_q;
        if (n_q == '0) begin
          rsp_data_d = '0;
          rsp_flag_d = 1'b0;
          state_d    = StResp;
        end else begin
          state_d = StMadd;
        end
      end
      StMadd: begin
        // Any carry during repeated adds means the true product exceeded the word.
        dp_a     = a_q;
        dp_sel0  = Sel0Add;
        dp_sel1  = Sel1Add;
        cnt_d    = cnt_q - WIDTH'(1);
        sticky_d = sticky_q | dp_cout;
        if (cnt_q == WIDTH'(1)) begin
          rsp_data_d = dp_s;
          rsp_flag_d = sticky_q | dp_cout;
          state_d    = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= OpLoad;
      a_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_flag = rsp_flag_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl against an arithmetic reference model.
module tb_acc_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_n;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_flag;

  int total;
  int bad;

  // Reference model state.
  int model_acc;
  int exp_data;
  int exp_flag;
  int exp_lat;

  acc_seq_ctrl #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_n    (cmd_n),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_flag (rsp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Results from plain arithmetic on the operation's meaning.
  task automatic model_apply(input int op, input int a, input int n);
    int r;
    case (op)
      0: begin r = a; exp_flag = 0; exp_lat = 1; end
      1: begin r = model_acc + a; exp_flag = (r > 15); exp_lat = 1; end
      2: begin r = model_acc - a; exp_flag = (model_acc >= a); exp_lat = 1; end
      default: begin
        r = a * n;
        exp_flag = (r > 15);
        exp_lat = (n == 0) ? 1 : 1 + n;
      end
    endcase
    r = r & 15;
    if (r < 0) r = r + 16;
    exp_data  = r;
    model_acc = r;
  endtask

  task automatic send_cmd(input int op, input int a, input int n);
    model_apply(op, a, n);
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_a     = 4'(a);
    cmd_n     = 4'(n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("cmd_ready_after_accept", cmd_ready, 0);
  endtask

  task automatic wait_rsp();
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_flag", rsp_flag, exp_flag);
    check_eq("acc_at_rsp", dut.dp_s, model_acc);
  endtask

  task automatic release_rsp(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall_valid", rsp_valid, 1);
      check_eq("stall_data", rsp_data, exp_data);
      check_eq("stall_acc", dut.dp_s, model_acc);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("valid_after_ack", rsp_valid, 0);
    check_eq("ready_after_ack", cmd_ready, 1);
  endtask

  task automatic run_cmd(input int op, input int a, input int n, input int stall);
    send_cmd(op, a, n);
    wait_rsp();
    release_rsp(stall);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    model_acc = 0;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_n = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    check_eq("reset_cmd_ready", cmd_ready, 1);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_rsp_flag", rsp_flag, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_acc", dut.dp_s, 0);
    end

    run_cmd(0, 5, 0, 0);
    run_cmd(1, 3, 0, 0);
    run_cmd(0, 3, 0, 0);
    run_cmd(2, 5, 0, 1);
    run_cmd(0, 8, 0, 0);
    run_cmd(2, 3, 0, 0);
    run_cmd(0, 9, 0, 0);
    run_cmd(1, 9, 0, 2);
    run_cmd(3, 3, 5, 0);
    run_cmd(3, 5, 4, 0);
    run_cmd(3, 7, 0, 0);

    // Backpressure with the next command already presented.
    send_cmd(1, 2, 0);
    wait_rsp();
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 4'd6;
    cmd_n     = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", rsp_valid, 1);
      check_eq("bp_data", rsp_data, exp_data);
      check_eq("bp_flag", rsp_flag, exp_flag);
      check_eq("bp_acc", dut.dp_s, model_acc);
      check_eq("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("bp_release_ready", cmd_ready, 1);
    check_eq("bp_release_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("bp_accept_next", cmd_ready, 0);
    model_apply(0, 6, 0);
    wait_rsp();
    release_rsp(0);

    // Reset in the middle of a long multiply.
    send_cmd(3, 3, 9);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    model_acc = 0;
    #1;
    check_eq("midreset_cmd_ready", cmd_ready, 1);
    check_eq("midreset_rsp_valid", rsp_valid, 0);
    check_eq("midreset_acc", dut.dp_s, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check_eq("no_rsp_after_reset", rsp_valid, 0);
    end
    run_cmd(0, 6, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
